sw_debouncer: RTL and testbench
===============================

SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 Parameter NB_SW, default 4, number of switch bits handled.
REQ-002 Parameter NB_COUNT, default 14, width of each per-bit stability counter.
REQ-003 Parameter DEB_LIMIT, default 10000, consecutive stable cycles required to accept a new level; legal range 2 to 2^NB_COUNT.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_sw  input  NB_SW  raw asynchronous switch levels from board pins.
REQ-007 o_sw  output  NB_SW  debounced, synchronised levels; feeds the LED-shifter switch input directly.
REQ-008 o_sw_rise  output  NB_SW  one-cycle pulse per bit on accepted 0->1 change (present only with edge feature).
REQ-009 o_sw_fall  output  NB_SW  one-cycle pulse per bit on accepted 1->0 change (present only with edge feature).

Function
REQ-010 Each i_sw bit SHALL pass a two-flop synchroniser; the second-flop output is the sampled level s[i].
REQ-011 Each bit SHALL own an independent NB_COUNT-bit counter cnt[i]; bits never interact.
REQ-012 When s[i] equals o_sw[i], cnt[i] SHALL be cleared to 0 on the next edge.
REQ-013 When s[i] differs from o_sw[i] and cnt[i] < DEB_LIMIT-1, cnt[i] SHALL increment by 1.
REQ-014 When s[i] differs from o_sw[i] and cnt[i] == DEB_LIMIT-1, o_sw[i] SHALL take s[i] and cnt[i] SHALL clear to 0 on the same edge.
REQ-015 Latency: an i_sw change settled before edge k and held SHALL appear on o_sw after edge k+DEB_LIMIT+1 (DEB_LIMIT+2 cycles).
REQ-016 Any return of s[i] to o_sw[i] before the limit SHALL discard progress (glitch rejection); counter never wraps.
REQ-017 o_sw_rise[i]/o_sw_fall[i] SHALL be registered and asserted exactly in the cycle o_sw[i] first shows its new value, for one cycle only.
REQ-018 o_sw_rise[i] and o_sw_fall[i] SHALL never be asserted together; simultaneous changes on several bits SHALL pulse all affected bits in the same cycle.
REQ-019 All outputs SHALL be driven directly from flops (no combinational path from i_sw).

Reset
REQ-020 While i_reset is high: synchroniser flops, cnt[], o_sw, o_sw_rise, o_sw_fall SHALL all be 0 after the next edge.
REQ-021 Reset asserted mid-count SHALL abandon the count; after release a full DEB_LIMIT+2 cycles of stable input SHALL be needed again.
REQ-022 A switch held high through reset SHALL produce o_sw high and a o_sw_rise pulse DEB_LIMIT+2 cycles after reset release.

Configuration
REQ-023 Macro SW_DEBOUNCER_EDGE_EN SHALL control edge outputs: defined -> o_sw_rise/o_sw_fall ports and their flops exist per REQ-017/018; undefined -> ports and logic are absent and o_sw behaviour is unchanged.

Structure
REQ-024 A shared package SHALL hold default NB_SW, NB_COUNT, DEB_LIMIT constants and a simulation DEB_LIMIT of 8 used by benches.
REQ-025 One sub-module debounce_bit (synchroniser, counter, level flop, optional edge flops for one bit) SHALL be instantiated NB_SW times via generate.

Verification (DEB_LIMIT=8, NB_SW=4)
REQ-026 Reset: i_reset=1, i_sw=4'hF for 3 cycles -> o_sw=4'h0, rise=fall=4'h0 throughout.
REQ-027 Clean step: i_sw 4'h0->4'h1 held -> o_sw=4'h1 exactly 10 cycles later, o_sw_rise=4'h1 for that single cycle only.
REQ-028 Glitch: i_sw[1] high for 5 cycles then low -> o_sw stays 4'h0, no pulses.
REQ-029 Bounce: i_sw[2] toggled every 3 cycles for 30 cycles then held 1 -> o_sw[2] rises once, 10 cycles after last transition; one rise pulse, zero fall pulses.
REQ-030 Simultaneous: i_sw 4'h0->4'hF then 4'hF->4'h0 after 20 cycles -> o_sw=4'hF with rise=4'hF in one cycle, later o_sw=4'h0 with fall=4'hF in one cycle.
REQ-031 Reset mid-count: i_sw=4'h8, assert i_reset when cnt[3]=5 for 1 cycle -> o_sw stays 4'h0, o_sw[3] rises exactly 10 cycles after reset release.

Source files
------------

// File: rtl/sw_debouncer_pkg.sv
// Shared constants for the switch debouncer: synthesis defaults and the short
// debounce limit that benches use to keep simulations brief.
package sw_debouncer_pkg;

    localparam int DEF_NB_SW     = 4;
    localparam int DEF_NB_COUNT  = 14;
    localparam int DEF_DEB_LIMIT = 10000;
    localparam int SIM_DEB_LIMIT = 8;

endpackage

// File: rtl/sw_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and debounced level.
// Edge pulse flops exist only when SW_DEBOUNCER_EDGE_EN is defined.
module debounce_bit
    import sw_debouncer_pkg::*;
#(
    parameter int NB_COUNT  = DEF_NB_COUNT,
    parameter int DEB_LIMIT = DEF_DEB_LIMIT
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sw,
    output logic o_sw
`ifdef SW_DEBOUNCER_EDGE_EN
    ,
    output logic o_sw_rise,
    output logic o_sw_fall
`endif
);

    localparam logic [NB_COUNT-1:0] LIMIT_M1 = NB_COUNT'(DEB_LIMIT - 1);

    logic                sync_meta;
    logic                sync_s;
    logic [NB_COUNT-1:0] cnt;
    logic                differ;
    logic                at_limit;

    always_comb begin
        differ   = (sync_s != o_sw);
        at_limit = (cnt == LIMIT_M1);
    end

    // Any sample matching the accepted level discards progress, so the
    // counter only reaches the limit after an unbroken run of the new level.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
            cnt       <= '0;
            o_sw      <= 1'b0;
        end else begin
            sync_meta <= i_sw;
            sync_s    <= sync_meta;
            if (!differ) begin
                cnt <= '0;
            end else if (at_limit) begin
                cnt  <= '0;
                o_sw <= sync_s;
            end else begin
                cnt <= cnt + NB_COUNT'(1);
            end
        end
    end

`ifdef SW_DEBOUNCER_EDGE_EN
    // Pulses are registered on the same edge that updates o_sw.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_sw_rise <= 1'b0;
            o_sw_fall <= 1'b0;
        end else begin
            o_sw_rise <= differ && at_limit && sync_s;
            o_sw_fall <= differ && at_limit && !sync_s;
        end
    end
`endif

endmodule

// File: rtl/sw_debouncer.sv
// Multi-bit switch debouncer: NB_SW independent debounce_bit slices.
// Define SW_DEBOUNCER_EDGE_EN to add the o_sw_rise/o_sw_fall pulse outputs.
module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int NB_SW     = DEF_NB_SW,
    parameter int NB_COUNT  = DEF_NB_COUNT,
    parameter int DEB_LIMIT = DEF_DEB_LIMIT
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw
`ifdef SW_DEBOUNCER_EDGE_EN
    ,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall
`endif
);

    for (genvar i = 0; i < NB_SW; i++) begin : g_bit
        debounce_bit #(
            .NB_COUNT  (NB_COUNT),
            .DEB_LIMIT (DEB_LIMIT)
        ) u_bit (
            .clock     (clock),
            .i_reset   (i_reset),
            .i_sw      (i_sw[i]),
            .o_sw      (o_sw[i])
`ifdef SW_DEBOUNCER_EDGE_EN
            ,
            .o_sw_rise (o_sw_rise[i]),
            .o_sw_fall (o_sw_fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with the short simulation debounce limit;
// edge pulse checks apply when SW_DEBOUNCER_EDGE_EN is defined.
module tb_sw_debouncer;
    import sw_debouncer_pkg::*;

    localparam int DL = SIM_DEB_LIMIT;
    localparam int LAT = DL + 2;

    logic       clock = 1'b0;
    logic       i_reset = 1'b1;
    logic [3:0] i_sw = 4'h0;
    logic [3:0] o_sw;
    logic [3:0] rise_v;
    logic [3:0] fall_v;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

`ifdef SW_DEBOUNCER_EDGE_EN
    logic [3:0] o_sw_rise;
    logic [3:0] o_sw_fall;
    assign rise_v = o_sw_rise;
    assign fall_v = o_sw_fall;
`else
    assign rise_v = 4'h0;
    assign fall_v = 4'h0;
`endif

    sw_debouncer #(
        .NB_SW     (4),
        .NB_COUNT  (4),
        .DEB_LIMIT (DL)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_sw      (i_sw),
        .o_sw      (o_sw)
`ifdef SW_DEBOUNCER_EDGE_EN
        ,
        .o_sw_rise (o_sw_rise),
        .o_sw_fall (o_sw_fall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [3:0] exp_sw;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic rst, input logic [3:0] sw, input logic [3:0] e_sw,
                        input logic [3:0] e_rise, input logic [3:0] e_fall,
                        input int n, input string name);
        vec_t v;
        v.rst = rst; v.sw = sw; v.exp_sw = e_sw;
        v.exp_rise = e_rise; v.exp_fall = e_fall; v.name = name;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Drive inputs, let one rising edge pass, then compare just after it.
    task automatic step_check(input logic rst, input logic [3:0] sw, input logic [3:0] e_sw,
                              input logic [3:0] e_rise, input logic [3:0] e_fall,
                              input string name);
        i_reset = rst;
        i_sw    = sw;
        @(posedge clock);
        #1;
        cyc++;
        checks++;
        if (o_sw !== e_sw) begin
            failures++;
            $display("FAIL %s cycle %0d o_sw=%h expected %h", name, cyc, o_sw, e_sw);
        end
`ifdef SW_DEBOUNCER_EDGE_EN
        checks++;
        if (rise_v !== e_rise || fall_v !== e_fall) begin
            failures++;
            $display("FAIL %s_edges cycle %0d rise=%h fall=%h expected rise=%h fall=%h",
                     name, cyc, rise_v, fall_v, e_rise, e_fall);
        end
`endif
    endtask

    initial begin
        // Reset with all switches high, then idle.
        push(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 3, "reset");
        push(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3, "idle");
        // Glitch on bit 1: 5 cycles high is far short of the limit.
        push(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 5, "glitch_hi");
        push(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 12, "glitch_lo");
        // Clean step on bit 0: accepted on the 10th edge.
        push(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, LAT - 1, "step_wait");
        push(1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 1, "step_rise");
        push(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 5, "step_hold");
        push(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, LAT - 1, "step_fwait");
        push(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1, "step_fall");
        push(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3, "step_idle");
        // All bits together, 20 cycles high then low.
        push(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, LAT - 1, "simul_wait");
        push(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1, "simul_rise");
        push(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 20 - LAT, "simul_hold");
        push(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, LAT - 1, "simul_fwait");
        push(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1, "simul_fall");
        push(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 3, "simul_idle");

        @(negedge clock);
        foreach (vecs[i])
            step_check(vecs[i].rst, vecs[i].sw, vecs[i].exp_sw,
                       vecs[i].exp_rise, vecs[i].exp_fall, vecs[i].name);

        // Bounce on bit 2: 3-cycle runs alternating for 30 cycles, then held high.
        for (int seg = 0; seg < 10; seg++)
            for (int k = 0; k < 3; k++)
                step_check(1'b0, (seg % 2 == 0) ? 4'h4 : 4'h0, 4'h0, 4'h0, 4'h0, "bounce");
        for (int j = 1; j <= LAT; j++)
            step_check(1'b0, 4'h4, (j == LAT) ? 4'h4 : 4'h0,
                       (j == LAT) ? 4'h4 : 4'h0, 4'h0, "bounce_settle");
        for (int j = 0; j < 4; j++)
            step_check(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, "bounce_hold");
        for (int j = 1; j <= LAT; j++)
            step_check(1'b0, 4'h0, (j == LAT) ? 4'h0 : 4'h4, 4'h0,
                       (j == LAT) ? 4'h4 : 4'h0, "bounce_release");
        step_check(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "bounce_idle");

        // Reset mid-count: after 7 edges the bit-3 counter sits at 5.
        for (int j = 0; j < 7; j++)
            step_check(1'b0, 4'h8, 4'h0, 4'h0, 4'h0, "midrst_count");
        step_check(1'b1, 4'h8, 4'h0, 4'h0, 4'h0, "midrst_reset");
        for (int j = 1; j <= LAT; j++)
            step_check(1'b0, 4'h8, (j == LAT) ? 4'h8 : 4'h0,
                       (j == LAT) ? 4'h8 : 4'h0, 4'h0, "midrst_release");
        step_check(1'b0, 4'h8, 4'h8, 4'h0, 4'h0, "midrst_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
